// File: rtl/pingpong_blk_collect.sv
// -----------------------------------------------------------------------------
// pingpong_blk_collect
//
// Collects the sub-block stream coming out of the pipelined 16:1 sub-block mux
// into one of two ping-pong banks. Each bank holds NUM_SUB entries plus a
// take-mask. A completed bank (closed by in_last) is offered downstream as one
// packed word through a valid/ready handshake. The bank currently being filled
// is exported as the turn signal for the mux stage.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   in_valid       beat present, aligned with the mux output
//   in_idx         sub-block index of the beat
//   in_last        final beat of the frame (closes the bank)
//   subblki        sub-block data from the mux
//   takeblki       beat is to be stored
//   wr_bank_o      bank currently being written (turn signal)
//   in_ready_o     advisory: target bank is free and no frame is being dropped
//   out_valid      a completed bank is available
//   out_ready      consumer accepts the bank
//   out_data       packed bank; entry i at [i*DATA_W +: DATA_W]
//   out_mask       bit i set when entry i was taken
//   overflow_o     sticky flag: at least one beat was dropped
//
// Optional feature (macro PINGPONG_STATS_EN):
//   frame_cnt_o    count of accepted frame-closing beats (wraps)
//   drop_cnt_o     count of dropped beats (wraps)
// -----------------------------------------------------------------------------
module pingpong_blk_collect #(
   parameter int DATA_W  = 8,
   parameter int NUM_SUB = 16,
   parameter int IDX_W   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [IDX_W-1:0]            in_idx,
   input  logic                        in_last,
   input  logic [DATA_W-1:0]           subblki,
   input  logic                        takeblki,
   output logic                        wr_bank_o,
   output logic                        in_ready_o,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W*NUM_SUB-1:0]   out_data,
   output logic [NUM_SUB-1:0]          out_mask,
   output logic                        overflow_o
`ifdef PINGPONG_STATS_EN
   ,
   output logic [15:0]                 frame_cnt_o,
   output logic [15:0]                 drop_cnt_o
`endif
);

   logic [DATA_W-1:0]  bank_data [2][NUM_SUB];
   logic [NUM_SUB-1:0] bank_mask [2];
   logic [1:0]         full;
   logic               wr_bank;
   logic               rd_bank;
   logic               drop_frame;
   logic               overflow;

   logic               wr_accept;
   logic               wr_drop;
   logic               rd_fire;

   // A beat is only taken into a free bank and never while the rest of an
   // overflowed frame is being discarded; this keeps frames whole.
   assign wr_accept = in_valid & ~full[wr_bank] & ~drop_frame;
   assign wr_drop   = in_valid & ~wr_accept;
   assign rd_fire   = full[rd_bank] & out_ready;

   assign wr_bank_o  = wr_bank;
   assign in_ready_o = ~full[wr_bank] & ~drop_frame;
   assign out_valid  = full[rd_bank];
   assign out_mask   = bank_mask[rd_bank];
   assign overflow_o = overflow;

   always_comb begin
      out_data = '0;
      for (int i = 0; i < NUM_SUB; i++) begin
         out_data[i*DATA_W +: DATA_W] = bank_data[rd_bank][i];
      end
   end

   // Read and write never target the same bank in one edge: a write needs
   // full=0 on its bank and a read needs full=1 on its bank. A bank freed on
   // this edge therefore cannot be written until the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            bank_mask[b] <= '0;
            for (int i = 0; i < NUM_SUB; i++) begin
               bank_data[b][i] <= '0;
            end
         end
         full       <= 2'b00;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         drop_frame <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (rd_fire) begin
            // Clearing on release makes untaken entries of the next frame read 0.
            full[rd_bank]      <= 1'b0;
            bank_mask[rd_bank] <= '0;
            for (int i = 0; i < NUM_SUB; i++) begin
               bank_data[rd_bank][i] <= '0;
            end
            rd_bank <= ~rd_bank;
         end

         if (wr_accept) begin
            if (takeblki) begin
               bank_data[wr_bank][in_idx] <= subblki;
               bank_mask[wr_bank][in_idx] <= 1'b1;
            end
            if (in_last) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
            end
         end else if (wr_drop) begin
            // Stay in drop mode until the frame's last beat has gone by.
            overflow   <= 1'b1;
            drop_frame <= ~in_last;
         end
      end
   end

`ifdef PINGPONG_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt_o <= 16'd0;
         drop_cnt_o  <= 16'd0;
      end else begin
         if (wr_accept && in_last) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
         end
         if (wr_drop) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
         end
      end
   end
`endif

endmodule
